// File: rtl/wishbone_dual.sv
// Dual-role Wishbone B4 classic bridge.
// Master side: an external agent moves one EXT_RW_WIDTH word as BEATS bus beats.
// Slave side: bus masters burst-write into, or burst-read from, an EXT_RW_WIDTH staging word.
// Handshake: a beat transfers when cyc & stb are high and ack is returned; the
// slave ack is registered and lasts exactly one cycle, and the master holds
// cyc/stb/adr/dat stable until it sees ack.
module wishbone_dual #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int EXT_RW_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wbs_cyc_i,
  input  logic                      wbs_stb_i,
  input  logic                      wbs_we_i,
  input  logic [ADDR_WIDTH-1:0]     wbs_adr_i,
  input  logic [DATA_WIDTH-1:0]     wbs_dat_i,
  input  logic [DATA_WIDTH/8-1:0]   wbs_sel_i,
  input  logic [2:0]                wbs_cti_i,
  input  logic [1:0]                wbs_bte_i,
  output logic [DATA_WIDTH-1:0]     wbs_dat_o,
  output logic                      wbs_ack_o,
  output logic                      wbm_cyc_o,
  output logic                      wbm_stb_o,
  output logic                      wbm_we_o,
  output logic [ADDR_WIDTH-1:0]     wbm_adr_o,
  output logic [DATA_WIDTH-1:0]     wbm_dat_o,
  output logic [DATA_WIDTH/8-1:0]   wbm_sel_o,
  output logic [2:0]                wbm_cti_o,
  output logic [1:0]                wbm_bte_o,
  input  logic [DATA_WIDTH-1:0]     wbm_dat_i,
  input  logic                      wbm_ack_i,
  input  logic                      ext_master_req,
  input  logic                      ext_master_we,
  input  logic [ADDR_WIDTH-1:0]     ext_master_addr_read,
  input  logic [ADDR_WIDTH-1:0]     ext_master_addr_write,
  input  logic [EXT_RW_WIDTH-1:0]   ext_master_wdata,
  output logic [EXT_RW_WIDTH-1:0]   ext_master_rdata,
  output logic                      ext_master_read_done,
  output logic                      ext_master_write_done,
  input  logic [EXT_RW_WIDTH-1:0]   ext_slave_wdata,
  output logic [EXT_RW_WIDTH-1:0]   ext_slave_rdata,
  output logic                      ext_slave_we,
  output logic [ADDR_WIDTH-1:0]     ext_slave_addr_read,
  output logic [ADDR_WIDTH-1:0]     ext_slave_addr_write,
  output logic                      ext_slave_read_done,
  output logic                      ext_slave_write_done,
  output logic [1:0]                master_state
);

  localparam int AW    = ADDR_WIDTH;
  localparam int DW    = DATA_WIDTH;
  localparam int EW    = EXT_RW_WIDTH;
  localparam int SW    = DW / 8;
  localparam int BEATS = EW / DW;
  localparam int CW    = $clog2(BEATS) + 1;

  localparam logic [1:0] M_IDLE = 2'd0;
  localparam logic [1:0] M_BEAT = 2'd1;
  localparam logic [1:0] M_GAP  = 2'd2;

  // Burst type/extension are meaningless for classic cycles.
  logic unused_ok;
  assign unused_ok = ^{wbs_cti_i, wbs_bte_i};

  // ---------------- master side ----------------
  logic [1:0]    m_state;
  logic          req_q;
  logic          m_we;
  logic [AW-1:0] m_base;
  logic [EW-1:0] m_wbuf;
  logic [EW-1:0] m_rbuf;
  logic [CW-1:0] m_cnt;
  logic [AW-1:0] m_off;

  assign master_state = m_state;
  assign m_off        = AW'(m_cnt) << 2;

  // Master bus outputs are decoded from the state so they are quiet in IDLE.
  assign wbm_cyc_o = (m_state != M_IDLE);
  assign wbm_stb_o = (m_state == M_BEAT);
  assign wbm_we_o  = wbm_cyc_o & m_we;
  assign wbm_adr_o = wbm_cyc_o ? (m_base + m_off) : '0;
  assign wbm_dat_o = (wbm_cyc_o && m_we) ? m_wbuf[m_cnt*DW +: DW] : '0;
  assign wbm_sel_o = '1;
  assign wbm_cti_o = 3'b000;
  assign wbm_bte_o = 2'b00;

  // Master FSM: edge-detect the request, then walk the beats with a one-cycle gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_state               <= M_IDLE;
      req_q                 <= 1'b0;
      m_we                  <= 1'b0;
      m_base                <= '0;
      m_wbuf                <= '0;
      m_rbuf                <= '0;
      m_cnt                 <= '0;
      ext_master_rdata      <= '0;
      ext_master_read_done  <= 1'b0;
      ext_master_write_done <= 1'b0;
    end else begin
      // Sampled every cycle so edges during a transfer are consumed, not queued.
      req_q <= ext_master_req;
      case (m_state)
        M_IDLE: begin
          if (ext_master_req && !req_q) begin
            m_we   <= ext_master_we;
            m_base <= ext_master_we ? ext_master_addr_write : ext_master_addr_read;
            m_wbuf <= ext_master_wdata;
            m_cnt  <= '0;
            if (ext_master_we) ext_master_write_done <= 1'b0;
            else               ext_master_read_done  <= 1'b0;
            m_state <= M_BEAT;
          end
        end
        M_BEAT: begin
          if (wbm_ack_i) begin
            if (!m_we) m_rbuf[m_cnt*DW +: DW] <= wbm_dat_i;
            m_state <= M_GAP;
          end
        end
        M_GAP: begin
          if (m_cnt == CW'(BEATS - 1)) begin
            m_cnt   <= '0;
            m_state <= M_IDLE;
            if (m_we) begin
              ext_master_write_done <= 1'b1;
            end else begin
              ext_master_rdata     <= m_rbuf;
              ext_master_read_done <= 1'b1;
            end
          end else begin
            m_cnt   <= m_cnt + CW'(1);
            m_state <= M_BEAT;
          end
        end
        default: m_state <= M_IDLE;
      endcase
    end
  end

  // ---------------- slave side ----------------
  logic          s_active;
  logic          s_we;
  logic [CW-1:0] s_cnt;
  logic [EW-1:0] s_wbuf;
  logic          s_accept;
  logic          s_first;
  logic [CW-1:0] s_idx;
  logic [CW-1:0] s_cnt_next;
  logic [EW-1:0] s_wbuf_next;

  // Beat decode; a new burst starts from the last published word so a
  // discarded partial burst never leaks into unselected bytes.
  always_comb begin
    s_accept    = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    s_first     = !s_active || (wbs_we_i != s_we);
    s_idx       = s_first ? '0 : s_cnt;
    s_cnt_next  = s_idx + CW'(1);
    s_wbuf_next = s_first ? ext_slave_rdata : s_wbuf;
    for (int b = 0; b < SW; b++) begin
      if (wbs_sel_i[b]) s_wbuf_next[s_idx*DW + b*8 +: 8] = wbs_dat_i[b*8 +: 8];
    end
  end

  // Slave burst tracking, registered ack and read data, completion publishing.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_active             <= 1'b0;
      s_we                 <= 1'b0;
      s_cnt                <= '0;
      s_wbuf               <= '0;
      wbs_ack_o            <= 1'b0;
      wbs_dat_o            <= '0;
      ext_slave_rdata      <= '0;
      ext_slave_we         <= 1'b0;
      ext_slave_addr_read  <= '0;
      ext_slave_addr_write <= '0;
      ext_slave_read_done  <= 1'b0;
      ext_slave_write_done <= 1'b0;
    end else begin
      wbs_ack_o <= s_accept;
      wbs_dat_o <= '0;
      if (s_accept) begin
        ext_slave_we <= wbs_we_i;
        s_we         <= wbs_we_i;
        if (s_first) begin
          if (wbs_we_i) begin
            ext_slave_addr_read <= wbs_adr_i;
            ext_slave_read_done <= 1'b0;
          end else begin
            ext_slave_addr_write <= wbs_adr_i;
            ext_slave_write_done <= 1'b0;
          end
        end
        if (wbs_we_i) s_wbuf    <= s_wbuf_next;
        else          wbs_dat_o <= ext_slave_wdata[s_idx*DW +: DW];
        if (s_cnt_next == CW'(BEATS)) begin
          s_active <= 1'b0;
          s_cnt    <= '0;
          if (wbs_we_i) begin
            ext_slave_rdata     <= s_wbuf_next;
            ext_slave_read_done <= 1'b1;
          end else begin
            ext_slave_write_done <= 1'b1;
          end
        end else begin
          s_active <= 1'b1;
          s_cnt    <= s_cnt_next;
        end
      end else if (!wbs_cyc_i) begin
        s_active <= 1'b0;
        s_cnt    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_wishbone_dual.sv
// Bench for wishbone_dual: instance 0 uses a 32-bit external word (1 beat),
// instance 1 a 256-bit word (8 beats). All driving and sampling at negedge.
module tb_wishbone_dual;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Inputs to the DUTs, index 0 = narrow, 1 = wide.
  logic [1:0]       s_cyc = '0, s_stb = '0, s_we_i = '0, m_ack = '0, req = '0, mwe = '0;
  logic [1:0][31:0] s_adr = '0, s_dat = '0, m_dat_i = '0, maddr_r = '0, maddr_w = '0;
  logic [1:0][3:0]  s_sel = '0;
  logic [1:0][2:0]  s_cti = '0;
  logic [1:0][1:0]  s_bte = '0;
  logic [31:0]      n_mwdata = '0, n_swdata = '0;
  logic [255:0]     w_mwdata = '0, w_swdata = '0;

  // DUT outputs.
  wire [1:0]       s_ack, m_cyc, m_stb, m_we, mrd_done, mwr_done, slv_we, srd_done, swr_done;
  wire [1:0][31:0] s_dato, m_adr, m_dato, slv_addr_r, slv_addr_w;
  wire [1:0][3:0]  m_sel;
  wire [1:0][2:0]  m_cti;
  wire [1:0][1:0]  m_bte, mstate;
  wire [31:0]      n_mrdata, n_srdata;
  wire [255:0]     w_mrdata, w_srdata;

  wishbone_dual u_narrow (
    .clk(clk), .rst(rst),
    .wbs_cyc_i(s_cyc[0]), .wbs_stb_i(s_stb[0]), .wbs_we_i(s_we_i[0]),
    .wbs_adr_i(s_adr[0]), .wbs_dat_i(s_dat[0]), .wbs_sel_i(s_sel[0]),
    .wbs_cti_i(s_cti[0]), .wbs_bte_i(s_bte[0]),
    .wbs_dat_o(s_dato[0]), .wbs_ack_o(s_ack[0]),
    .wbm_cyc_o(m_cyc[0]), .wbm_stb_o(m_stb[0]), .wbm_we_o(m_we[0]),
    .wbm_adr_o(m_adr[0]), .wbm_dat_o(m_dato[0]), .wbm_sel_o(m_sel[0]),
    .wbm_cti_o(m_cti[0]), .wbm_bte_o(m_bte[0]),
    .wbm_dat_i(m_dat_i[0]), .wbm_ack_i(m_ack[0]),
    .ext_master_req(req[0]), .ext_master_we(mwe[0]),
    .ext_master_addr_read(maddr_r[0]), .ext_master_addr_write(maddr_w[0]),
    .ext_master_wdata(n_mwdata), .ext_master_rdata(n_mrdata),
    .ext_master_read_done(mrd_done[0]), .ext_master_write_done(mwr_done[0]),
    .ext_slave_wdata(n_swdata), .ext_slave_rdata(n_srdata), .ext_slave_we(slv_we[0]),
    .ext_slave_addr_read(slv_addr_r[0]), .ext_slave_addr_write(slv_addr_w[0]),
    .ext_slave_read_done(srd_done[0]), .ext_slave_write_done(swr_done[0]),
    .master_state(mstate[0])
  );

  wishbone_dual #(.EXT_RW_WIDTH(256)) u_wide (
    .clk(clk), .rst(rst),
    .wbs_cyc_i(s_cyc[1]), .wbs_stb_i(s_stb[1]), .wbs_we_i(s_we_i[1]),
    .wbs_adr_i(s_adr[1]), .wbs_dat_i(s_dat[1]), .wbs_sel_i(s_sel[1]),
    .wbs_cti_i(s_cti[1]), .wbs_bte_i(s_bte[1]),
    .wbs_dat_o(s_dato[1]), .wbs_ack_o(s_ack[1]),
    .wbm_cyc_o(m_cyc[1]), .wbm_stb_o(m_stb[1]), .wbm_we_o(m_we[1]),
    .wbm_adr_o(m_adr[1]), .wbm_dat_o(m_dato[1]), .wbm_sel_o(m_sel[1]),
    .wbm_cti_o(m_cti[1]), .wbm_bte_o(m_bte[1]),
    .wbm_dat_i(m_dat_i[1]), .wbm_ack_i(m_ack[1]),
    .ext_master_req(req[1]), .ext_master_we(mwe[1]),
    .ext_master_addr_read(maddr_r[1]), .ext_master_addr_write(maddr_w[1]),
    .ext_master_wdata(w_mwdata), .ext_master_rdata(w_mrdata),
    .ext_master_read_done(mrd_done[1]), .ext_master_write_done(mwr_done[1]),
    .ext_slave_wdata(w_swdata), .ext_slave_rdata(w_srdata), .ext_slave_we(slv_we[1]),
    .ext_slave_addr_read(slv_addr_r[1]), .ext_slave_addr_write(slv_addr_w[1]),
    .ext_slave_read_done(srd_done[1]), .ext_slave_write_done(swr_done[1]),
    .master_state(mstate[1])
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0]  exp_q[$];      // read beats returned by the bus, in order
  logic [255:0] stage [2];     // last published slave word per instance

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int beats(input int k);
    return (k == 1) ? 8 : 1;
  endfunction

  function automatic logic [255:0] get_mrdata(input int k);
    return (k == 1) ? w_mrdata : {224'd0, n_mrdata};
  endfunction

  function automatic logic [255:0] get_srdata(input int k);
    return (k == 1) ? w_srdata : {224'd0, n_srdata};
  endfunction

  function automatic logic [255:0] get_swdata(input int k);
    return (k == 1) ? w_swdata : {224'd0, n_swdata};
  endfunction

  // One external-agent transfer; the bench plays the bus slave, acking one
  // cycle after it sees stb. Optionally pulses req low/high mid-transfer.
  task automatic master_xfer(input int k, input bit we, input logic [31:0] base,
                             input logic [255:0] wdata, input bit glitch);
    int nb;
    int waited;
    logic [31:0]  d;
    logic [255:0] exp_word;
    logic prev_rd, prev_wr;
    nb      = beats(k);
    prev_rd = mrd_done[k];
    prev_wr = mwr_done[k];
    mwe[k]  = we;
    if (we) begin maddr_w[k] = base; maddr_r[k] = $urandom; end
    else    begin maddr_r[k] = base; maddr_w[k] = $urandom; end
    if (k == 1) w_mwdata = wdata; else n_mwdata = wdata[31:0];
    req[k] = 1'b1;
    for (int i = 0; i < nb; i++) begin
      waited = 0;
      tick();
      while (!m_stb[k] && waited < 20) begin tick(); waited++; end
      if (!m_stb[k]) begin
        chk("m_stb_timeout", m_stb[k], 1);
        req[k] = 1'b0;
        return;
      end
      chk("m_adr", m_adr[k], base + 32'(4 * i));
      chk("m_we", m_we[k], we);
      chk("m_cyc", m_cyc[k], 1);
      if (we) chk("m_wdat", m_dato[k], wdata[i*32 +: 32]);
      if (i == 0) chk("m_done_cleared", we ? mwr_done[k] : mrd_done[k], 0);
      if (glitch && i == 2) req[k] = 1'b0;
      if (glitch && i == 4) req[k] = 1'b1;
      tick();
      chk("m_stb_hold", m_stb[k], 1);
      d = $urandom;
      m_dat_i[k] = d;
      m_ack[k]   = 1'b1;
      if (!we) exp_q.push_back(d);
      tick();
      m_ack[k]   = 1'b0;
      m_dat_i[k] = '0;
      chk("m_gap_stb", m_stb[k], 0);
      chk("m_gap_cyc", m_cyc[k], 1);
    end
    tick();
    chk("m_cyc_drop", m_cyc[k], 0);
    if (we) begin
      chk("m_write_done", mwr_done[k], 1);
      chk("m_read_done_kept", mrd_done[k], prev_rd);
    end else begin
      chk("m_read_done", mrd_done[k], 1);
      chk("m_write_done_kept", mwr_done[k], prev_wr);
      exp_word = '0;
      for (int i = 0; i < nb; i++) exp_word[i*32 +: 32] = exp_q.pop_front();
      chk("m_rdata", get_mrdata(k), exp_word);
    end
  endtask

  // Confirm the master stays idle for n cycles (no retrigger).
  task automatic master_idle(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("m_no_retrigger", m_stb[k], 0);
    end
  endtask

  // One bus beat into the slave; write data merges into the working word.
  task automatic slave_beat(input int k, input bit we, input logic [31:0] adr, input int idx,
                            input logic [3:0] sel, inout logic [255:0] work);
    logic [31:0] d;
    d = $urandom;
    s_cyc[k] = 1'b1; s_stb[k] = 1'b1; s_we_i[k] = we;
    s_adr[k] = adr;  s_dat[k] = d;    s_sel[k] = sel;
    tick();
    chk("s_ack", s_ack[k], 1);
    if (we) begin
      chk("s_dato_wr", s_dato[k], 0);
      for (int b = 0; b < 4; b++) if (sel[b]) work[idx*32 + b*8 +: 8] = d[b*8 +: 8];
    end else begin
      chk("s_dato_rd", s_dato[k], get_swdata(k)[idx*32 +: 32]);
    end
    s_stb[k] = 1'b0;
    tick();
    chk("s_ack_pulse", s_ack[k], 0);
    chk("s_dato_idle", s_dato[k], 0);
  endtask

  // A burst of nb beats; nb below the full count is a discarded partial burst.
  task automatic slave_burst(input int k, input bit we, input logic [31:0] base,
                             input int nb, input bit rand_sel);
    logic [255:0] work;
    logic [3:0]   sel;
    work = stage[k];
    for (int i = 0; i < nb; i++) begin
      sel = rand_sel ? 4'($urandom_range(0, 15)) : 4'hF;
      slave_beat(k, we, base + 32'(4 * i), i, sel, work);
    end
    s_cyc[k] = 1'b0;
    tick();
    chk("s_we_last", slv_we[k], we);
    if (nb == beats(k)) begin
      if (we) begin
        stage[k] = work;
        chk("s_rdata", get_srdata(k), stage[k]);
        chk("s_addr_read", slv_addr_r[k], base);
        chk("s_read_done", srd_done[k], 1);
      end else begin
        chk("s_addr_write", slv_addr_w[k], base);
        chk("s_write_done", swr_done[k], 1);
      end
    end else begin
      chk("s_partial_done", we ? srd_done[k] : swr_done[k], 0);
      chk("s_partial_rdata", get_srdata(k), stage[k]);
    end
  endtask

  // Watchdog: the sequence is far shorter than this.
  initial begin
    #2000000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [255:0] work;
    logic [31:0]  base;
    stage[0] = '0;
    stage[1] = '0;

    // Reset held for five cycles.
    rst = 1'b1;
    repeat (5) tick();
    rst = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) begin
      chk("rst_mrd_done", mrd_done[k], 0);
      chk("rst_mwr_done", mwr_done[k], 0);
      chk("rst_srd_done", srd_done[k], 0);
      chk("rst_swr_done", swr_done[k], 0);
      chk("rst_m_cyc", m_cyc[k], 0);
      chk("rst_s_ack", s_ack[k], 0);
      chk("rst_m_sel", m_sel[k], 4'hF);
      chk("rst_m_cti_bte", {m_cti[k], m_bte[k]}, 0);
      chk("rst_m_rdata", get_mrdata(k), 0);
      chk("rst_s_rdata", get_srdata(k), 0);
    end

    // Narrow master read of 0x1000.
    master_xfer(0, 1'b0, 32'h0000_1000, '0, 1'b0);
    req[0] = 1'b0;
    tick();

    // Narrow master write, req held well past completion.
    master_xfer(0, 1'b1, 32'h0000_2000, {224'd0, 32'hCAFE_BABE}, 1'b0);
    master_idle(0, 4);
    req[0] = 1'b0;
    tick();
    chk("m_write_done_sticky", mwr_done[0], 1);

    // Narrow slave write at 0x3000 and read at 0x4000.
    slave_burst(0, 1'b1, 32'h0000_3000, 1, 1'b0);
    n_swdata = 32'hAB12_3456;
    slave_burst(0, 1'b0, 32'h0000_4000, 1, 1'b0);

    // Narrow random traffic.
    for (int r = 0; r < 6; r++) begin
      base = $urandom & 32'hFFFF_FFFC;
      master_xfer(0, 1'($urandom_range(0, 1)), base, {224'd0, 32'($urandom)}, 1'b0);
      req[0] = 1'b0;
      n_swdata = $urandom;
      slave_burst(0, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, 1, 1'b1);
    end

    // Wide master read: 8 beats, with a request glitch that must be ignored.
    master_xfer(1, 1'b0, 32'h0000_8000, '0, 1'b1);
    master_idle(1, 4);
    req[1] = 1'b0;
    tick();
    for (int r = 0; r < 2; r++) begin
      work = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      master_xfer(1, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFF0, work, 1'b0);
      req[1] = 1'b0;
      tick();
    end

    // Wide slave: full write with random selects, full read, partial discard.
    slave_burst(1, 1'b1, 32'h0000_A000, 8, 1'b0);
    slave_burst(1, 1'b1, 32'h0000_A100, 8, 1'b1);
    w_swdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    slave_burst(1, 1'b0, 32'h0000_B000, 8, 1'b0);
    slave_burst(1, 1'b1, 32'h0000_C000, 5, 1'b0);
    slave_burst(1, 1'b1, 32'h0000_C100, 8, 1'b1);

    // Direction change mid-burst: partial write is dropped, read restarts at beat 0.
    work = stage[1];
    for (int i = 0; i < 3; i++) slave_beat(1, 1'b1, 32'h0000_D000 + 32'(4 * i), i, 4'hF, work);
    for (int i = 0; i < 8; i++) slave_beat(1, 1'b0, 32'h0000_E000 + 32'(4 * i), i, 4'hF, work);
    s_cyc[1] = 1'b0;
    tick();
    chk("s_dir_write_done", swr_done[1], 1);
    chk("s_dir_read_done", srd_done[1], 0);
    chk("s_dir_addr_write", slv_addr_w[1], 32'h0000_E000);
    chk("s_dir_rdata_kept", get_srdata(1), stage[1]);

    // Reset in the middle of a wide master read aborts it.
    maddr_r[1] = 32'h0000_F000;
    mwe[1] = 1'b0;
    req[1] = 1'b1;
    repeat (3) tick();
    chk("abort_busy", m_cyc[1], 1);
    rst = 1'b1;
    req[1] = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("abort_cyc", m_cyc[1], 0);
    chk("abort_read_done", mrd_done[1], 0);
    chk("abort_rdata", get_mrdata(1), 0);
    chk("abort_sel", m_sel[1], 4'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
